// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: RUN switch and STEP button front end.
// Debounced inputs drive a run/step/halt FSM and an issued-cycle counter.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned RUN_DIV         = 3_125_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_clk_en,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int DVW = $clog2(RUN_DIV);
  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST =
    DVW'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_e;

  // bit 0: run switch, bit 1: step button
  logic [1:0]          s1_q, s2_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0][DBW-1:0] cnt_q, cnt_d;
  logic                step_prev_q;
  logic [DVW-1:0]      div_q, div_d;
  logic [CNT_W-1:0]    count_q, count_d;
  state_e              state_q, state_d;

  logic run_stable;
  logic step_req;
  logic en;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign run_stable = stable_q[0];
  assign step_req   = stable_q[1] & ~step_prev_q;

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    if (halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_stable) begin
            state_d = RUN;
          end else if (step_req) begin
            state_d = STEP;
          end
        end
        RUN: begin
          if (!run_stable) begin
            state_d = IDLE;
          end else if (div_q != DIV_LAST) begin
            div_d = div_q + 1'b1;
          end
        end
        STEP:    state_d = IDLE;
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  assign en = ((state_q == STEP) |
               ((state_q == RUN) & (div_q == DIV_LAST)))
              & ~halt;

  assign count_d = count_q + CNT_W'(en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      step_prev_q <= 1'b0;
      div_q       <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
    end else begin
      s1_q        <= {step_btn, run_sw};
      s2_q        <= s1_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      step_prev_q <= stable_q[1];
      div_q       <= div_d;
      count_q     <= count_d;
      state_q     <= state_d;
    end
  end

  assign cpu_clk_en = en;
  assign step_count = count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with a cycle-level reference model.
// Model predicts pulses into a queue; a negedge monitor pops and compares.
module tb_cpu_step_ctrl;

  localparam int D = 4;
  localparam int R = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;
  logic        cpu_clk_en, en4;
  logic [31:0] step_count;
  logic [3:0]  cnt4;
  logic [1:0]  state, st4;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(D), .RUN_DIV(R), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw),
    .step_btn(step_btn), .halt(halt),
    .cpu_clk_en(cpu_clk_en), .step_count(step_count),
    .state(state)
  );

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(D), .RUN_DIV(R), .CNT_W(4)
  ) dut4 (
    .clk(clk), .rst(rst), .run_sw(run_sw),
    .step_btn(step_btn), .halt(halt),
    .cpu_clk_en(en4), .step_count(cnt4),
    .state(st4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   cyc_n = 0;

  // reference model: mode 0 IDLE, 1 RUN, 2 STEP, 3 HALTED
  int m_mode = 0;
  int m_phase = 0;
  int m_cnt = 0;
  bit m_pend = 0;
  bit m_rs = 0, m_ss = 0, m_ss_prev = 0;
  int m_rrun = 0, m_srun = 0;
  bit m_r1 = 0, m_r2 = 0, m_t1 = 0, m_t2 = 0;

  task automatic m_reset();
    m_mode = 0; m_phase = 0; m_cnt = 0; m_pend = 0;
    m_rs = 0; m_ss = 0; m_ss_prev = 0;
    m_rrun = 0; m_srun = 0;
    m_r1 = 0; m_r2 = 0; m_t1 = 0; m_t2 = 0;
    q.delete();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      bit req;
      int nmode;
      cyc_n++;
      if (m_pend) m_cnt++;
      m_pend = 0;
      req = m_ss && !m_ss_prev;
      nmode = m_mode;
      if (halt) nmode = 3;
      else if (m_mode == 0) begin
        if (m_rs) nmode = 1;
        else if (req) nmode = 2;
      end else if (m_mode == 1) begin
        if (!m_rs) nmode = 0;
      end else if (m_mode == 2) nmode = 0;
      if (nmode == 1 && m_mode == 1)
        m_phase = (m_phase + 1) % R;
      else
        m_phase = 0;
      m_ss_prev = m_ss;
      // a level is accepted after D consecutive differing samples
      if (m_r2 != m_rs) begin
        m_rrun++;
        if (m_rrun == D) begin m_rs = m_r2; m_rrun = 0; end
      end else m_rrun = 0;
      if (m_t2 != m_ss) begin
        m_srun++;
        if (m_srun == D) begin m_ss = m_t2; m_srun = 0; end
      end else m_srun = 0;
      m_r2 = m_r1; m_r1 = run_sw;
      m_t2 = m_t1; m_t1 = step_btn;
      m_mode = nmode;
      #4;
      if (!rst && !halt &&
          (m_mode == 2 || (m_mode == 1 && m_phase == R - 1))) begin
        q.push_back('{cyc_n, m_cnt});
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (state !== 2'(m_mode) || st4 !== 2'(m_mode)) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d/%0d exp=%0d",
                 cyc_n, state, st4, m_mode);
      end
      checks++;
      if (step_count !== 32'(m_cnt) || cnt4 !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL count cyc=%0d got=%0d/%0d exp=%0d",
                 cyc_n, step_count, cnt4, m_cnt);
      end
      if (cpu_clk_en !== 1'b0 || en4 !== 1'b0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b/%b exp=0",
                   cyc_n, cpu_clk_en, en4);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc_n || cpu_clk_en !== 1'b1 ||
              en4 !== 1'b1 || step_count !== 32'(e.cnt)) begin
            errors++;
            $display("FAIL pulse got cyc=%0d cnt=%0d exp cyc=%0d cnt=%0d",
                     cyc_n, step_count, e.cyc, e.cnt);
          end
        end
      end else if (q.size() > 0 && q[0].cyc == cyc_n) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse cyc=%0d got=0 exp=1", cyc_n);
        void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic press(input int hold, input int gap);
    step_btn = 1'b1;
    cyc(hold);
    step_btn = 1'b0;
    cyc(gap);
  endtask

  task automatic do_reset();
    #4;
    rst = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_en", cpu_clk_en, 0);
    chk("rst_count", step_count, 0);
    chk("rst_count4", cnt4, 0);
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint base;
    int hs, hr, t;
    hs = 0;
    hr = 0;
    cyc(2);

    run_sw = 1'b1;
    cyc(10);
    do_reset();
    cyc(5);
    chk("rerun_early", state, 0);
    cyc(2);
    chk("rerun_state", state, 1);
    run_sw = 1'b0;
    cyc(15);

    base = step_count;
    step_btn = 1'b1;
    cyc(6);
    chk("press_pre_en", cpu_clk_en, 0);
    cyc(1);
    chk("press_state", state, 2);
    chk("press_en", cpu_clk_en, 1);
    cyc(1);
    chk("press_after", state, 0);
    chk("press_cnt", step_count - base, 1);
    cyc(12);
    step_btn = 1'b0;
    cyc(10);
    chk("press_total", step_count - base, 1);

    base = step_count;
    for (int i = 0; i < 5; i++) begin
      step_btn = (i % 2 == 0);
      cyc(1);
    end
    step_btn = 1'b1;
    cyc(12);
    step_btn = 1'b0;
    cyc(10);
    chk("bounce_cnt", step_count - base, 1);
    base = step_count;
    step_btn = 1'b1;
    cyc(3);
    step_btn = 1'b0;
    cyc(10);
    chk("glitch_cnt", step_count - base, 0);

    base = step_count;
    run_sw = 1'b1;
    cyc(12);
    step_btn = 1'b1;
    cyc(8);
    step_btn = 1'b0;
    cyc(10);
    run_sw = 1'b0;
    cyc(3);
    chk("run_hold", state, 1);
    cyc(12);
    chk("run_idle", state, 0);
    chk("run_cnt", step_count - base, 10);

    do_reset();
    cyc(2);
    for (int i = 0; i < 17; i++) begin
      press(8, 8);
      if (i == 14) chk("wrap_15", cnt4, 15);
      if (i == 15) chk("wrap_0", cnt4, 0);
    end
    chk("wrap_1", cnt4, 1);
    chk("wrap_full", step_count, 17);

    for (int i = 0; i < 400; i++) begin
      if (hs == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 9);
      end else hs--;
      if (hr == 0) begin
        run_sw = 1'($urandom_range(0, 1));
        hr = $urandom_range(1, 40);
      end else hr--;
      cyc(1);
    end
    run_sw = 1'b0;
    step_btn = 1'b0;
    cyc(20);

    run_sw = 1'b1;
    t = 0;
    while (t < 200 && !(m_mode == 1 && m_phase == R - 1)) begin
      cyc(1);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL halt_wait got=timeout exp=run_phase");
    end
    halt = 1'b1;
    base = step_count;
    #1;
    chk("halt_gate", cpu_clk_en, 0);
    cyc(1);
    halt = 1'b0;
    chk("halt_state", state, 3);
    press(8, 8);
    run_sw = 1'b0;
    cyc(10);
    run_sw = 1'b1;
    cyc(15);
    press(8, 8);
    chk("halt_sticky", state, 3);
    chk("halt_cnt", step_count - base, 0);
    do_reset();
    run_sw = 1'b0;
    cyc(10);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
